// File: rtl/button_debounce.sv
// button_debounce: per-channel 2-FF synchroniser plus confirm FSM for active-low buttons; optional long-press strobe under BTN_DEBOUNCE_LONGPRESS_EN
module button_debounce #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  ,
  output logic [NUM_BTN-1:0] long_press
`endif
);
  localparam int MAX_CNT = DEBOUNCE_CYCLES > LONG_CYCLES ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  typedef enum logic [1:0] {RELEASED, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE} state_t;
  logic [NUM_BTN-1:0] sync1, sync2;
  // bring the async pins into the clock domain; idle high so reset exit shows no edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             clean, pp, rp;
    // confirm FSM: the switch occurs on the edge that completes DEBOUNCE_CYCLES stable samples, any bounce restarts the window
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        state <= RELEASED;
        cnt   <= '0;
        clean <= 1'b1;
        pp    <= 1'b0;
        rp    <= 1'b0;
      end else begin
        pp <= 1'b0;
        rp <= 1'b0;
        case (state)
          RELEASED: if (!sync2[g]) begin
            state <= CONFIRM_PRESS;
            cnt   <= '0;
          end
          CONFIRM_PRESS: if (sync2[g]) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
            state <= PRESSED;
            cnt   <= '0;
            clean <= 1'b0;
            pp    <= 1'b1;
          end else cnt <= cnt + 1'b1;
          PRESSED: if (sync2[g]) begin
            state <= CONFIRM_RELEASE;
            cnt   <= '0;
          end
          CONFIRM_RELEASE: if (!sync2[g]) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
            state <= RELEASED;
            cnt   <= '0;
            clean <= 1'b1;
            rp    <= 1'b1;
          end else cnt <= cnt + 1'b1;
        endcase
      end
    assign btn_clean[g]     = clean;
    assign press_pulse[g]   = pp;
    assign release_pulse[g] = rp;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    logic [CNT_W-1:0] hold;
    logic             lp;
    // hold timer: saturates at LONG_CYCLES so exactly one strobe fires per press
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        hold <= '0;
        lp   <= 1'b0;
      end else begin
        lp   <= state == PRESSED && hold == CNT_W'(LONG_CYCLES - 1);
        hold <= state != PRESSED ? '0 : hold + CNT_W'(hold < CNT_W'(LONG_CYCLES));
      end
    assign long_press[g] = lp;
`endif
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: randomized and directed checks of button_debounce against a sliding-window reference model
module tb_button_debounce;
  localparam int D = 8;
  localparam int L = 32;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_clean, press_pulse, release_pulse, long_press;
  int         total = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  button_debounce #(.NUM_BTN(2), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .btn_clean(btn_clean),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    ,
    .long_press(long_press)
`endif
  );
`ifndef BTN_DEBOUNCE_LONGPRESS_EN
  assign long_press = 2'b00;
`endif

  // Reference: the level flips once the D raw samples taken 2..D+1 edges ago all hold the new value.
  typedef struct packed {
    logic [D+1:0][1:0] hist;
    logic [1:0]        clean, press, rel, lng;
    logic [1:0][7:0]   hold;
  } model_t;
  localparam model_t M_RST = {{(2*(D+2)){1'b1}}, 2'b11, 6'b0, 16'b0};
  model_t m;

  function automatic model_t step(model_t cur, logic [1:0] raw);
    model_t n;
    int ones;
    n = cur;
    n.hist = {cur.hist[D:0], raw};
    n.press = '0;
    n.rel = '0;
    n.lng = '0;
    for (int c = 0; c < 2; c++) begin
      ones = 0;
      for (int k = 2; k <= D + 1; k++) ones += int'(n.hist[k][c]);
      if (cur.clean[c] && ones == 0) begin
        n.clean[c] = 1'b0;
        n.press[c] = 1'b1;
        n.hold[c] = 8'd0;
      end else if (!cur.clean[c] && ones == D) begin
        n.clean[c] = 1'b1;
        n.rel[c] = 1'b1;
        n.hold[c] = 8'd0;
      end else if (!cur.clean[c] && !n.hist[3][c]) begin
        n.lng[c] = cur.hold[c] == 8'(L - 1);
        if (cur.hold[c] < 8'(L)) n.hold[c] = cur.hold[c] + 8'd1;
      end else n.hold[c] = 8'd0;
    end
    return n;
  endfunction

  // model state advances on the same edges as the DUT
  always @(posedge clk or negedge reset_n)
    if (!reset_n) m <= M_RST;
    else m <= step(m, btn_raw);

  logic [7:0] obs, expv;
  assign obs  = {btn_clean, press_pulse, release_pulse, long_press};
  assign expv = {m.clean, m.press, m.rel, m.lng & {2{LP}}};

  task automatic test_reset();
    reset_n = 1'b0;
    btn_raw = 2'b11;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (obs !== 8'b11_00_00_00) $display("FAIL reset_hold got %b exp %b", obs, 8'b11_00_00_00);
      else passed++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (obs !== 8'b11_00_00_00) $display("FAIL reset_idle cyc %0d got %b exp %b", i, obs, 8'b11_00_00_00);
      else passed++;
    end
  endtask

  task automatic test_press_latency();
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      total++;
      if ({btn_clean, press_pulse} !== {1'b1, k < 10, 1'b0, k == 10})
        $display("FAIL press_latency edge %0d got clean=%b press=%b", k, btn_clean, press_pulse);
      else passed++;
      total++;
      if (obs !== expv) $display("FAIL press_model edge %0d got %b exp %b", k, obs, expv);
      else passed++;
    end
  endtask

  task automatic test_bounce();
    btn_raw = 2'b11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) $display("FAIL bounce_prep cyc %0d got %b exp %b", i, obs, expv);
      else passed++;
    end
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) btn_raw[0] = ~btn_raw[0];
      @(negedge clk);
      total++;
      if ({btn_clean[0], press_pulse[0], release_pulse[0]} !== 3'b100)
        $display("FAIL bounce_quiet cyc %0d got %b exp 100", i, {btn_clean[0], press_pulse[0], release_pulse[0]});
      else passed++;
      total++;
      if (obs !== expv) $display("FAIL bounce_model cyc %0d got %b exp %b", i, obs, expv);
      else passed++;
    end
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if ({btn_clean[0], press_pulse[0]} !== {k < 10, k == 10})
        $display("FAIL bounce_settle edge %0d got clean=%b press=%b", k, btn_clean[0], press_pulse[0]);
      else passed++;
    end
  endtask

  task automatic test_simultaneous_release();
    btn_raw = 2'b00;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) $display("FAIL both_press cyc %0d got %b exp %b", i, obs, expv);
      else passed++;
    end
    btn_raw = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if ({release_pulse, btn_clean} !== {(k == 10) ? 2'b11 : 2'b00, (k >= 10) ? 2'b11 : 2'b00})
        $display("FAIL both_release edge %0d got rel=%b clean=%b", k, release_pulse, btn_clean);
      else passed++;
      total++;
      if (obs !== expv) $display("FAIL both_model edge %0d got %b exp %b", k, obs, expv);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_confirm();
    btn_raw[0] = 1'b0;
    repeat (7) begin
      @(negedge clk);
      total++;
      if (obs !== expv) $display("FAIL midrst_pre got %b exp %b", obs, expv);
      else passed++;
    end
    reset_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (obs !== 8'b11_00_00_00) $display("FAIL midrst_hold got %b exp %b", obs, 8'b11_00_00_00);
      else passed++;
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      total++;
      if ({btn_clean[0], press_pulse[0]} !== {k < 10, k == 10})
        $display("FAIL midrst_fresh edge %0d got clean=%b press=%b", k, btn_clean[0], press_pulse[0]);
      else passed++;
      total++;
      if (obs !== expv) $display("FAIL midrst_model edge %0d got %b exp %b", k, obs, expv);
      else passed++;
    end
  endtask

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  task automatic test_long_press();
    bit seen;
    btn_raw = 2'b11;
    repeat (20) @(negedge clk);
    btn_raw[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = press_pulse[1];
    end
    total++;
    if (!seen) $display("FAIL long_wait_press got none exp press_pulse[1] within 20 cycles");
    else passed++;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      total++;
      if (long_press[1] !== (k == 32)) $display("FAIL long_strobe cyc %0d got %b exp %b", k, long_press[1], k == 32);
      else passed++;
      total++;
      if (obs !== expv) $display("FAIL long_model cyc %0d got %b exp %b", k, obs, expv);
      else passed++;
    end
    btn_raw[1] = 1'b1;
    repeat (20) @(negedge clk);
    btn_raw[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      total++;
      if (long_press !== 2'b00) $display("FAIL long_short cyc %0d got %b exp 00", k, long_press);
      else passed++;
    end
    btn_raw[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if (obs !== expv) $display("FAIL long_rel_model cyc %0d got %b exp %b", k, obs, expv);
      else passed++;
    end
  endtask
`endif

  task automatic test_random();
    int p;
    for (int s = 0; s < 30; s++) begin
      p = (s % 3 == 0) ? 2 : (s % 3 == 1) ? 10 : 40;
      if ($urandom_range(0, 9) == 0) begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
      end
      for (int i = 0; i < 100; i++) begin
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, 99) < p) btn_raw[c] = ~btn_raw[c];
        @(negedge clk);
        total++;
        if (obs !== expv) $display("FAIL random seg %0d cyc %0d got %b exp %b", s, i, obs, expv);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_simultaneous_release();
    test_reset_mid_confirm();
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    test_long_press();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish exp finish before 1000000");
    $fatal(1);
  end
endmodule
